gdiv_u_seq: RTL and testbench

Job sequencer for the unipolar unary divider. Accepts binary dividend/divisor operands over a valid/ready handshake and generates the two unary input bitstreams plus the divider's DEP-bit random number. It resets and warms up an external divider instance, then counts its quotient stream over one full stream period. The binary quotient is returned over a second valid/ready handshake. It sits between binary-domain logic and one shared divider instance, and owns that instance exclusively.

---
 rtl/gdiv_u_seq_if.sv | 32 +++
 rtl/gdiv_u_seq.sv | 148 ++++++++++++++
 tb/tb_gdiv_u_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gdiv_u_seq_if.sv
// Handshake and divider-facing signal bundle for the unary divider job sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface gdiv_u_seq_if #(
  parameter int BW  = 8,
  parameter int DEP = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [BW-1:0]  in_dividend;
  logic [BW-1:0]  in_divisor;
  logic           div_rst_n;
  logic [DEP-1:0] div_randNum;
  logic           div_dividend;
  logic           div_divisor;
  logic           div_quotient;
  logic           out_valid;
  logic           out_ready;
  logic [BW:0]    out_quotient;
  logic           out_err;

  modport slave (
    input  in_valid, in_dividend, in_divisor, div_quotient, out_ready,
    output in_ready, div_rst_n, div_randNum, div_dividend, div_divisor,
           out_valid, out_quotient, out_err
  );

  modport master (
    output in_valid, in_dividend, in_divisor, div_quotient, out_ready,
    input  in_ready, div_rst_n, div_randNum, div_dividend, div_divisor,
           out_valid, out_quotient, out_err
  );
endinterface

// File: rtl/gdiv_u_seq.sv
// Job sequencer for a unipolar unary divider: turns a binary operand pair into
// two unary streams, resets and warms up the divider, then counts its quotient
// stream over one full 2^BW-cycle stream period.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CLR   | one-cycle divider reset, counters and LFSR reinitialised
// WARM  | streams driven, quotient ignored while the divider settles
// RUN   | streams driven, quotient ones accumulated for 2^BW cycles
// DONE  | result presented until out_ready
module gdiv_u_seq #(
  parameter int BW   = 8,
  parameter int DEP  = 5,
  parameter int WARM = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  gdiv_u_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_WARM = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BW:0] WARM_LAST = (BW+1)'(WARM - 1);
  localparam logic [BW:0] RUN_LAST  = (BW+1)'((1 << BW) - 1);

  // Fibonacci feedback taps (bit positions of the shift register), maximal length
  localparam logic [7:0] TAP_ALL = (DEP == 4) ? 8'h0C :
                                   (DEP == 5) ? 8'h14 :
                                   (DEP == 6) ? 8'h30 :
                                   (DEP == 7) ? 8'h60 : 8'hB8;
  localparam logic [DEP-1:0] TAPS = TAP_ALL[DEP-1:0];

  logic [2:0]     state_q, state_d;
  logic [BW-1:0]  dvd_q, dvd_d;
  logic [BW-1:0]  dvs_q, dvs_d;
  logic           err_q, err_d;
  logic [BW-1:0]  sc_q, sc_d;
  logic [BW:0]    cnt_q, cnt_d;
  logic [BW:0]    acc_q, acc_d;
  logic [DEP-1:0] lfsr_q, lfsr_d;
  logic           div_rst_n_q, div_rst_n_d;

  logic [BW-1:0]  sc_rev;
  logic [DEP-1:0] lfsr_next;
  logic           active;

  // Bit-reversed stream counter and the next LFSR value
  always_comb begin
    sc_rev = '0;
    for (int i = 0; i < BW; i++) sc_rev[i] = sc_q[BW-1-i];
    lfsr_next = {lfsr_q[DEP-2:0], ^(lfsr_q & TAPS)};
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.in_dividend;
          dvs_d   = bus.in_divisor;
          err_d   = bus.in_dividend > bus.in_divisor;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        sc_d    = '0;
        cnt_d   = '0;
        acc_d   = '0;
        lfsr_d  = '1;
        state_d = S_WARM;
      end
      S_WARM: begin
        sc_d   = sc_q + BW'(1);
        lfsr_d = lfsr_next;
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + (BW+1)'(1);
        end
      end
      S_RUN: begin
        sc_d   = sc_q + BW'(1);
        lfsr_d = lfsr_next;
        acc_d  = acc_q + {{BW{1'b0}}, bus.div_quotient};
        if (cnt_q == RUN_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + (BW+1)'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    div_rst_n_d = (state_d != S_CLR);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      err_q       <= 1'b0;
      sc_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      lfsr_q      <= '1;
      div_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      err_q       <= err_d;
      sc_q        <= sc_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lfsr_q      <= lfsr_d;
      div_rst_n_q <= div_rst_n_d;
    end
  end

  assign active = (state_q == S_WARM) || (state_q == S_RUN);

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.div_rst_n    = div_rst_n_q;
  assign bus.div_randNum  = lfsr_q;
  assign bus.div_dividend = active && (dvd_q > sc_q);
  assign bus.div_divisor  = active && (dvs_q > sc_rev);
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.out_quotient = (state_q == S_DONE) ? acc_q : '0;
  assign bus.out_err      = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_gdiv_u_seq.sv
// Self-checking bench for gdiv_u_seq with a behavioural unary divider attached.
module tb_gdiv_u_seq;
  localparam int BW   = 8;
  localparam int DEP  = 5;
  localparam int WARM = 16;
  localparam int PER  = 1 << BW;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  gdiv_u_seq_if #(.BW(BW), .DEP(DEP)) bus ();

  gdiv_u_seq #(.BW(BW), .DEP(DEP), .WARM(WARM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Gradient-descent style unary divider: quotient estimate counter compared
  // against the random number, nudged toward dividend = divisor * quotient.
  logic [DEP-1:0] dcnt = 5'd16;
  logic           dq;
  assign dq = dcnt > bus.div_randNum;
  assign bus.div_quotient = dq;
  always @(posedge clk) begin
    if (!bus.div_rst_n) dcnt <= 5'd16;
    else if (bus.div_divisor) begin
      if (bus.div_dividend && !dq && dcnt != 5'd31) dcnt <= dcnt + 5'd1;
      else if (!bus.div_dividend && dq && dcnt != 5'd0) dcnt <= dcnt - 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int brev8(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < BW; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job; abort_at >= 0 pulses reset during that RUN cycle instead of finishing.
  task automatic run_job(input int dvd, input int dvs, input int hold, input int abort_at);
    int  w = 0;
    int  sc, exp_acc, bad_str, bad_ctl, bad_lfsr, bad_hold;
    bit  seen [0:31];
    bit  aborted = 0;
    int  exp_err = (dvd > dvs) ? 1 : 0;
    exp_acc = 0; bad_str = 0; bad_ctl = 0; bad_lfsr = 0; bad_hold = 0;
    for (int i = 0; i < 32; i++) seen[i] = 0;

    while (bus.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    chk("ready_before_job", 32'(bus.in_ready), 32'd1);
    bus.in_dividend = 8'(dvd);
    bus.in_divisor  = 8'(dvs);
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("clr_div_rst_n", 32'(bus.div_rst_n), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    chk("clr_streams", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);

    for (int k = 0; k < WARM + PER && !aborted; k++) begin
      tick();
      sc = k % PER;
      if (bus.div_dividend !== (dvd > sc)) bad_str++;
      if (bus.div_divisor !== (dvs > brev8(sc))) bad_str++;
      if (bus.div_rst_n !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad_ctl++;
      if (k == 0) chk("lfsr_seed", 32'(bus.div_randNum), 32'd31);
      if (k < 31) begin
        if (bus.div_randNum == 0 || seen[bus.div_randNum]) bad_lfsr++;
        seen[bus.div_randNum] = 1;
      end
      if (k >= WARM && bus.div_quotient) exp_acc++;
      if (abort_at >= 0 && k == WARM + abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_quotient", 32'(bus.out_quotient), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_div_rst_n", 32'(bus.div_rst_n), 32'd0);
        chk("rst_streams", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
        chk("rst_randnum", 32'(bus.div_randNum), 32'd31);
        tick();
        chk("rst_after_div_rst_n", 32'(bus.div_rst_n), 32'd1);
        chk("rst_after_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_after_streams", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
        aborted = 1;
      end
    end
    chk("stream_bits", 32'(bad_str), 32'd0);
    chk("ctl_during_job", 32'(bad_ctl), 32'd0);
    chk("lfsr_distinct", 32'(bad_lfsr), 32'd0);
    if (aborted) return;

    tick();
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    chk("done_out_quotient", 32'(bus.out_quotient), 32'(exp_acc));
    chk("done_out_err", 32'(bus.out_err), 32'(exp_err));
    chk("done_streams", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_quotient !== 9'(exp_acc) ||
          bus.out_err !== 1'(exp_err) || bus.in_ready !== 1'b0) bad_hold++;
    end
    chk("hold_stable", 32'(bad_hold), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_out_quotient", 32'(bus.out_quotient), 32'd0);
  endtask

  initial begin
    int rd, rs;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b0;
    repeat (3) tick();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_quotient", 32'(bus.out_quotient), 32'd0);
    chk("reset_out_err", 32'(bus.out_err), 32'd0);
    chk("reset_div_rst_n", 32'(bus.div_rst_n), 32'd0);
    chk("reset_streams", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
    chk("reset_randnum", 32'(bus.div_randNum), 32'd31);
    rst_n = 1'b1;
    tick();
    chk("release_div_rst_n", 32'(bus.div_rst_n), 32'd1);

    run_job(0, 128, 0, -1);
    run_job(255, 255, 0, -1);
    run_job(64, 128, 0, -1);
    run_job(200, 100, 10, -1);
    run_job(37, 0, 0, -1);
    run_job(64, 128, 0, 100);
    run_job(64, 128, 0, -1);
    for (int j = 0; j < 3; j++) begin
      rd = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 255));
      run_job(rd, rs, int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
